// File: rtl/counter_pkg.sv
// Shared constants for the modulo-N key counter: key indices, LEDR flag bits, defaults.
// Used by both builds (KEY_DEBOUNCE_EN defined or undefined).
package counter_pkg;

    localparam int unsigned KEY_RST = 0;
    localparam int unsigned KEY_UP  = 1;
    localparam int unsigned KEY_DN  = 2;
    localparam int unsigned KEY_LD  = 3;

    localparam int unsigned FLAG_CARRY  = 0;
    localparam int unsigned FLAG_BORROW = 1;
    localparam int unsigned FLAG_WRAP   = 2;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 50000;

endpackage

// File: rtl/key_conditioner.sv
// One push-button path: 2-flop synchroniser, optional debounce filter (KEY_DEBOUNCE_EN),
// arm bit and single-cycle press pulse on a 1->0 transition of the filtered level.
module key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = counter_pkg::DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_ni,
    output logic press_o
);

    logic       sync1_q, sync2_q;
    logic [1:0] vld_q;
    logic       level;
    logic       prev_q;
    logic       armed_q, armed_d;

    if (DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    // vld_q[1] marks that sync2_q holds a real sample rather than its reset value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            vld_q   <= 2'b00;
        end else begin
            sync1_q <= key_ni;
            sync2_q <= sync1_q;
            vld_q   <= {vld_q[0], 1'b1};
        end
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            filt_q, filt_d;

    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync2_q != filt_q) begin
            if (cnt_q == CntLast) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            filt_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    // Arm only once a genuine released level is seen, so a key held through reset is ignored.
    assign armed_d = armed_q | (vld_q[1] & sync2_q & level);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q  <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= level;
            armed_q <= armed_d;
        end
    end

    assign press_o = armed_q & prev_q & ~level;

endmodule

// File: rtl/mod_n_key_counter.sv
// Modulo-N up/down counter driven by conditioned push-buttons, with carry/borrow/wrap flags.
// Define KEY_DEBOUNCE_EN to insert a debounce filter in each key path.
module mod_n_key_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned MODULUS         = 16,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             CLOCK_50,
    input  logic [3:0]       KEY,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] LEDG,
    output logic [2:0]       LEDR
);

    localparam logic [WIDTH:0]   ModExt = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_param_check
        $error("MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    logic             rst_n;
    logic [3:1]       press;
    logic [WIDTH-1:0] sw1_q, sw_q;
    logic [WIDTH-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             wrap_q, wrap_d;

    assign rst_n = KEY[KEY_RST];

    for (genvar i = KEY_UP; i <= KEY_LD; i++) begin : g_key
        key_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .clk_i  (CLOCK_50),
            .rst_ni (rst_n),
            .key_ni (KEY[i]),
            .press_o(press[i])
        );
    end

    always_comb begin
        count_d  = count_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (press[KEY_LD]) begin
            count_d = ({1'b0, sw_q} >= ModExt) ? MaxVal : sw_q;
        end else if (press[KEY_UP] && press[KEY_DN]) begin
            count_d = count_q;
        end else if (press[KEY_UP]) begin
            if (count_q == MaxVal) begin
                count_d = '0;
                carry_d = 1'b1;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end else if (press[KEY_DN]) begin
            if (count_q == '0) begin
                count_d  = MaxVal;
                borrow_d = 1'b1;
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
        wrap_d = wrap_q | carry_d | borrow_d;
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sw1_q    <= '0;
            sw_q     <= '0;
            count_q  <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            sw1_q    <= SW;
            sw_q     <= sw1_q;
            count_q  <= count_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            wrap_q   <= wrap_d;
        end
    end

    assign LEDG              = count_q;
    assign LEDR[FLAG_CARRY]  = carry_q;
    assign LEDR[FLAG_BORROW] = borrow_q;
    assign LEDR[FLAG_WRAP]   = wrap_q;

endmodule

// File: tb/tb_mod_n_key_counter.sv
// Scoreboard bench for mod_n_key_counter (WIDTH=4, MODULUS=10, DEBOUNCE_CYCLES=4);
// latencies follow KEY_DEBOUNCE_EN so the same file covers both builds.
module tb_mod_n_key_counter;

    localparam int unsigned DEB = 4;
`ifdef KEY_DEBOUNCE_EN
    localparam int unsigned LAT = 3 + DEB;
`else
    localparam int unsigned LAT = 3;
`endif

    typedef struct {
        int unsigned cyc;
        logic [3:0]  g;
        logic [2:0]  r;
    } exp_t;

    logic        clk = 1'b0;
    logic [3:0]  key;
    logic [3:0]  sw;
    logic [3:0]  ledg;
    logic [2:0]  ledr;
    int unsigned cyc = 0;
    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic        finishing = 1'b0;
    logic        mon_done = 1'b0;

    mod_n_key_counter #(
        .WIDTH          (4),
        .MODULUS        (10),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .CLOCK_50(clk),
        .KEY     (key),
        .SW      (sw),
        .LEDG    (ledg),
        .LEDR    (ledr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic expect_at(input int unsigned c, input logic [3:0] g, input logic [2:0] r);
        sb_q.push_back('{c, g, r});
    endtask

    // Monitor: pops every expectation due this cycle and compares against the outputs.
    always @(negedge clk) begin
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL stale: check for cycle %0d never taken (now %0d)", sb_q[0].cyc, cyc);
            void'(sb_q.pop_front());
        end
        while (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            e = sb_q.pop_front();
            n_checks++;
            if (ledg !== e.g) begin
                n_fail++;
                $display("FAIL ledg @%0d: got %0d, expected %0d", cyc, ledg, e.g);
            end
            n_checks++;
            if (ledr !== e.r) begin
                n_fail++;
                $display("FAIL ledr @%0d: got %b, expected %b", cyc, ledr, e.r);
            end
        end
        if (finishing && !mon_done) begin
            foreach (sb_q[i]) begin
                n_checks++;
                n_fail++;
                $display("FAIL pending: check for cycle %0d left unchecked", sb_q[i].cyc);
            end
            sb_q.delete();
            mon_done = 1'b1;
        end
    end

    // One press of the keys in mask; g0/r0 before the update edge, g1/r1 on it, r2 one cycle on.
    task automatic press(input logic [3:1] mask, input logic [3:0] sw_v,
                         input logic [3:0] g0, input logic [2:0] r0,
                         input logic [3:0] g1, input logic [2:0] r1, input logic [2:0] r2);
        int unsigned t0;
        @(negedge clk);
        sw = sw_v;
        key[3:1] = ~mask;
        t0 = cyc;
        expect_at(t0 + LAT - 1, g0, r0);
        expect_at(t0 + LAT, g1, r1);
        expect_at(t0 + LAT + 1, g1, r2);
        repeat (LAT + 2) @(negedge clk);
        key[3:1] = 3'b111;
        repeat (LAT + 3) @(negedge clk);
    endtask

    initial begin
        int unsigned t0;
        key = 4'b1110;
        sw  = 4'd0;
        repeat (2) @(negedge clk);
        expect_at(cyc + 1, 4'd0, 3'b000);
        @(negedge clk);
        @(negedge clk);
        key[0] = 1'b1;
        repeat (6) @(negedge clk);

        for (int i = 1; i <= 9; i++) begin
            press(3'b001, 4'd0, 4'(i - 1), 3'b000, 4'(i), 3'b000, 3'b000);
        end
        press(3'b001, 4'd0, 4'd9, 3'b000, 4'd0, 3'b101, 3'b100);
        press(3'b010, 4'd0, 4'd0, 3'b100, 4'd9, 3'b110, 3'b100);
        press(3'b100, 4'd7, 4'd9, 3'b100, 4'd7, 3'b100, 3'b100);
        press(3'b100, 4'd12, 4'd7, 3'b100, 4'd9, 3'b100, 3'b100);
        press(3'b101, 4'd3, 4'd9, 3'b100, 4'd3, 3'b100, 3'b100);
        press(3'b100, 4'd5, 4'd3, 3'b100, 4'd5, 3'b100, 3'b100);
        press(3'b011, 4'd5, 4'd5, 3'b100, 4'd5, 3'b100, 3'b100);

`ifdef KEY_DEBOUNCE_EN
        // Bounce: 3 low, 1 high, then held low; only the final settled fall counts.
        @(negedge clk);
        key[1] = 1'b0;
        repeat (3) @(negedge clk);
        key[1] = 1'b1;
        @(negedge clk);
        key[1] = 1'b0;
        t0 = cyc;
        expect_at(t0 + 2, 4'd5, 3'b100);
        expect_at(t0 + LAT - 1, 4'd5, 3'b100);
        expect_at(t0 + LAT, 4'd6, 3'b100);
        repeat (10) @(negedge clk);
        key[1] = 1'b1;
        expect_at(cyc + LAT + 2, 4'd6, 3'b100);
        repeat (LAT + 3) @(negedge clk);
`endif

        // Up key held low through reset release must not count.
        @(negedge clk);
        key[0] = 1'b0;
        key[1] = 1'b0;
        expect_at(cyc + 1, 4'd0, 3'b000);
        repeat (2) @(negedge clk);
        key[0] = 1'b1;
        t0 = cyc;
        expect_at(t0 + LAT + 1, 4'd0, 3'b000);
        expect_at(t0 + LAT + 4, 4'd0, 3'b000);
        repeat (LAT + 6) @(negedge clk);
        key[1] = 1'b1;
        expect_at(cyc + LAT + 2, 4'd0, 3'b000);
        repeat (LAT + 3) @(negedge clk);
        press(3'b001, 4'd0, 4'd0, 3'b000, 4'd1, 3'b000, 3'b000);

        // Reset asserted while a press is still in the key pipeline.
        @(negedge clk);
        key[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        key[0] = 1'b0;
        expect_at(cyc, 4'd0, 3'b000);
        @(negedge clk);
        key[1] = 1'b1;
        repeat (2) @(negedge clk);
        key[0] = 1'b1;
        t0 = cyc;
        expect_at(t0 + LAT + 2, 4'd0, 3'b000);
        expect_at(t0 + 2 * LAT, 4'd0, 3'b000);
        repeat (2 * LAT + 2) @(negedge clk);
        press(3'b001, 4'd0, 4'd0, 3'b000, 4'd1, 3'b000, 3'b000);

        @(negedge clk);
        finishing = 1'b1;
        for (int i = 0; i < 10 && !mon_done; i++) @(negedge clk);
        if (!mon_done) begin
            $display("FAIL monitor: scoreboard did not drain");
            $fatal(1, "monitor stalled");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
